// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_t;

    // DMA counts as the most recent winner out of reset, so the core wins
    // the first contention.
    localparam port_t RESET_LAST = PORT_DMA;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select between the core and DMA requesters.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       i_c_req,
    input  logic       i_d_req,
    input  port_t      i_last,
    output logic [1:0] o_grant,   // bit 0 = core, bit 1 = DMA
    output logic       o_valid
);

    // A lone requester always wins; under contention the port not granted last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_c_req && i_d_req) begin
            o_grant = (i_last == PORT_DMA) ? 2'b01 : 2'b10;
        end else if (i_c_req) begin
            o_grant = 2'b01;
        end else if (i_d_req) begin
            o_grant = 2'b10;
        end
    end

    assign o_valid = i_c_req | i_d_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the shared instruction/data memory port.
// Runs one transaction at a time (IDLE -> ACCESS -> RESP) and aborts
// accesses that see no mem_ready within TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    port_t         r_owner;
    logic          r_own_vld;
    port_t         r_last;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_c_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic [1:0]    w_grant;
    logic          w_valid;
    port_t         w_win;
    logic          w_timeout;

    rr_pick2 u_pick (
        .i_c_req (c_req),
        .i_d_req (d_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_win     = w_grant[1] ? PORT_DMA : PORT_CORE;
    assign w_timeout = (r_cnt == CNT_LAST);

    // Transaction sequencer: grant and latch in IDLE, wait in ACCESS, ack in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= PORT_CORE;
            r_own_vld   <= 1'b0;
            r_last      <= RESET_LAST;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner     <= w_win;
                        r_own_vld   <= 1'b1;
                        r_last      <= w_win;
                        r_mem_we    <= w_grant[1] ? d_we    : c_we;
                        r_mem_addr  <= w_grant[1] ? d_addr  : c_addr;
                        r_mem_wdata <= w_grant[1] ? d_wdata : c_wdata;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_ready wins over a simultaneous timeout.
                    if (mem_ready || w_timeout) begin
                        r_rdata   <= mem_ready ? mem_rdata : '0;
                        r_err     <= ~mem_ready;
                        r_mem_req <= 1'b0;
                        r_c_ack   <= r_own_vld && (r_owner == PORT_CORE);
                        r_d_ack   <= r_own_vld && (r_owner == PORT_DMA);
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_c_ack   <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_err     <= 1'b0;
                    r_own_vld <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign c_ack     = r_c_ack;
    assign d_ack     = r_d_ack;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign c_stall   = c_req & ~r_c_ack;

endmodule
